// File: rtl/vr_burst_packer.sv
// vr_burst_packer
// Buffers a valid/ready sample stream in a FIFO and replays it as fixed-length
// bursts. A burst only starts once BURST_LEN samples are buffered, so every
// burst is emitted without gaps. A remainder shorter than a burst stays
// buffered until enough samples arrive to complete it.
//
// Ports:
//   clk       in   single clock, rising edge
//   rst       in   asynchronous active-high reset
//   i_data    in   input sample
//   i_valid   in   input sample valid
//   i_ready   out  block can accept a sample (buffer not full)
//   o_bdata   out  burst beat data (FIFO head)
//   o_bvalid  out  burst beat valid
//   o_bready  in   consumer accepts the beat
//   o_bfirst  out  current beat is the first of its burst
//   o_blast   out  current beat is the last of its burst
//   o_fill    out  number of buffered samples
module vr_burst_packer #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned BURST_LEN = 8,
    parameter int unsigned DEPTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_valid,
    output logic                     i_ready,
    output logic [WIDTH-1:0]         o_bdata,
    output logic                     o_bvalid,
    input  logic                     o_bready,
    output logic                     o_bfirst,
    output logic                     o_blast,
    output logic [$clog2(DEPTH):0]   o_fill
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = $clog2(BURST_LEN);

    typedef enum logic {StIdle, StBurst} state_e;

    state_e         r_state;
    state_e         w_state_next;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [CW-1:0]  r_count;
    logic [CW-1:0]  w_count_next;
    logic [BW-1:0]  r_beat;
    logic           w_wr;
    logic           w_rd;
    logic           w_beat_last;
    logic           w_burst_ready;

    // Ready depends only on the registered count: a same-cycle read does not
    // free a slot for a same-cycle write when full.
    assign i_ready       = (r_count < CW'(DEPTH));
    assign w_wr          = i_valid && i_ready;
    assign w_rd          = o_bvalid && o_bready;
    assign w_beat_last   = (r_beat == BW'(BURST_LEN - 1));
    assign w_burst_ready = (w_count_next >= CW'(BURST_LEN));

    always_comb begin
        w_count_next = r_count;
        if (w_wr && !w_rd) begin
            w_count_next = r_count + CW'(1);
        end else if (w_rd && !w_wr) begin
            w_count_next = r_count - CW'(1);
        end
    end

    // Data RAM carries no reset; contents are only observed while o_bvalid=1.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_beat  <= '0;
        end else begin
            r_count <= w_count_next;
            if (w_wr) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_rd) begin
                r_rptr <= r_rptr + AW'(1);
                r_beat <= w_beat_last ? '0 : r_beat + BW'(1);
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next state. Entering or staying in BURST requires a whole burst to
    // be buffered, which guarantees a gap-free burst.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_burst_ready) begin
                    w_state_next = StBurst;
                end
            end
            StBurst: begin
                if (w_rd && w_beat_last && !w_burst_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        o_bvalid = (r_state == StBurst);
        o_bfirst = o_bvalid && (r_beat == '0);
        o_blast  = o_bvalid && w_beat_last;
        o_bdata  = r_mem[r_rptr];
        o_fill   = r_count;
    end

endmodule

// File: tb/tb_vr_burst_packer.sv
// tb_vr_burst_packer
// Directed self-checking bench for vr_burst_packer with BURST_LEN=4, DEPTH=8.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at
// the same point, before the next edge commits the transfer.
module tb_vr_burst_packer;

    localparam int unsigned WIDTH     = 16;
    localparam int unsigned BURST_LEN = 4;
    localparam int unsigned DEPTH     = 8;

    logic              clk;
    logic              rst;
    logic [WIDTH-1:0]  i_data;
    logic              i_valid;
    logic              i_ready;
    logic [WIDTH-1:0]  o_bdata;
    logic              o_bvalid;
    logic              o_bready;
    logic              o_bfirst;
    logic              o_blast;
    logic [3:0]        o_fill;

    int vec_cnt;
    int err_cnt;

    vr_burst_packer #(
        .WIDTH     (WIDTH),
        .BURST_LEN (BURST_LEN),
        .DEPTH     (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_data   (i_data),
        .i_valid  (i_valid),
        .i_ready  (i_ready),
        .o_bdata  (o_bdata),
        .o_bvalid (o_bvalid),
        .o_bready (o_bready),
        .o_bfirst (o_bfirst),
        .o_blast  (o_blast),
        .o_fill   (o_fill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Drains one burst of BURST_LEN beats with o_bready=1, checking each beat.
    task automatic drain_burst(input string name, input logic [WIDTH-1:0] first_val);
        logic [18:0] got;
        logic [18:0] exp;
        o_bready = 1'b1;
        for (int k = 0; k < BURST_LEN; k++) begin
            got = {o_bvalid, o_bfirst, o_blast, o_bdata};
            exp = {1'b1, (k == 0), (k == BURST_LEN - 1), first_val + WIDTH'(k)};
            vec_cnt++;
            if (got !== exp) begin
                err_cnt++;
                $display("FAIL %s beat %0d: got v/f/l/data=%h required %h", name, k, got, exp);
            end
            step();
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1;
        vec_cnt++;
        if ({o_bvalid, o_bfirst, o_blast, i_ready, o_fill} !== {4'b0001, 4'd0}) begin
            err_cnt++;
            $display("FAIL reset_outputs: got v/f/l/rdy/fill=%b required %b",
                     {o_bvalid, o_bfirst, o_blast, i_ready, o_fill}, {4'b0001, 4'd0});
        end
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic;
        o_bready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            i_data  = WIDTH'(i);
            i_valid = 1'b1;
            vec_cnt++;
            if (i_ready !== 1'b1 || o_bvalid !== 1'b0) begin
                err_cnt++;
                $display("FAIL basic_fill %0d: got rdy=%b bvalid=%b required rdy=1 bvalid=0",
                         i, i_ready, o_bvalid);
            end
            step();
        end
        i_valid = 1'b0;
        drain_burst("basic", 16'h0001);
        vec_cnt++;
        if (o_bvalid !== 1'b0 || o_fill !== 4'd0) begin
            err_cnt++;
            $display("FAIL basic_end: got bvalid=%b fill=%0d required 0 0", o_bvalid, o_fill);
        end
    endtask

    task automatic test_partial;
        o_bready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_data  = 16'h0010 + WIDTH'(i);
            i_valid = 1'b1;
            step();
        end
        i_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            vec_cnt++;
            if (o_bvalid !== 1'b0 || o_fill !== 4'd3) begin
                err_cnt++;
                $display("FAIL partial_hold cyc %0d: got bvalid=%b fill=%0d required 0 3",
                         c, o_bvalid, o_fill);
            end
            step();
        end
        i_data  = 16'h0013;
        i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        drain_burst("partial", 16'h0010);
    endtask

    task automatic test_full;
        logic [18:0] got;
        logic [18:0] exp;
        o_bready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            i_data  = WIDTH'(i + 1);
            i_valid = 1'b1;
            step();
        end
        vec_cnt++;
        if (o_fill !== 4'd8 || i_ready !== 1'b0 || o_bdata !== 16'h0001 || o_bvalid !== 1'b1) begin
            err_cnt++;
            $display("FAIL full_state: got fill=%0d rdy=%b bdata=%h bvalid=%b required 8 0 0001 1",
                     o_fill, i_ready, o_bdata, o_bvalid);
        end
        i_data = 16'h0009;
        step();
        i_valid = 1'b0;
        vec_cnt++;
        if (o_fill !== 4'd8 || o_bdata !== 16'h0001) begin
            err_cnt++;
            $display("FAIL full_reject9: got fill=%0d bdata=%h required 8 0001", o_fill, o_bdata);
        end
        o_bready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            got = {o_bvalid, o_bfirst, o_blast, o_bdata};
            exp = {1'b1, ((k % 4) == 0), ((k % 4) == 3), WIDTH'(k + 1)};
            vec_cnt++;
            if (got !== exp) begin
                err_cnt++;
                $display("FAIL full_b2b beat %0d: got v/f/l/data=%h required %h", k, got, exp);
            end
            step();
        end
        vec_cnt++;
        if (o_bvalid !== 1'b0 || o_fill !== 4'd0) begin
            err_cnt++;
            $display("FAIL full_end: got bvalid=%b fill=%0d required 0 0", o_bvalid, o_fill);
        end
    endtask

    task automatic test_stall;
        logic [18:0] got;
        logic [18:0] exp;
        int idx;
        o_bready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            i_data  = 16'h0031 + WIDTH'(i);
            i_valid = 1'b1;
            step();
        end
        i_valid = 1'b0;
        idx = 0;
        for (int c = 0; c < 64 && idx < 4; c++) begin
            o_bready = ($urandom_range(0, 1) == 1) || (c >= 40);
            got = {o_bvalid, o_bfirst, o_blast, o_bdata};
            exp = {1'b1, (idx == 0), (idx == 3), 16'h0031 + WIDTH'(idx)};
            vec_cnt++;
            if (got !== exp) begin
                err_cnt++;
                $display("FAIL stall cyc %0d beat %0d: got v/f/l/data=%h required %h",
                         c, idx, got, exp);
            end
            if (o_bready) begin
                idx++;
            end
            step();
        end
        o_bready = 1'b1;
        vec_cnt++;
        if (idx != 4 || o_bvalid !== 1'b0) begin
            err_cnt++;
            $display("FAIL stall_done: got beats=%0d bvalid=%b required 4 0", idx, o_bvalid);
        end
    endtask

    task automatic test_reset_mid;
        o_bready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            i_data  = 16'h0041 + WIDTH'(i);
            i_valid = 1'b1;
            step();
        end
        i_valid  = 1'b0;
        o_bready = 1'b0;
        // Two beats of the first burst have already transferred here.
        #2;
        rst = 1'b1;
        #1;
        vec_cnt++;
        if ({o_bvalid, o_bfirst, o_blast, i_ready, o_fill} !== {4'b0001, 4'd0}) begin
            err_cnt++;
            $display("FAIL reset_mid: got v/f/l/rdy/fill=%b required %b",
                     {o_bvalid, o_bfirst, o_blast, i_ready, o_fill}, {4'b0001, 4'd0});
        end
        step();
        rst = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            i_data  = 16'h00A0 + WIDTH'(i);
            i_valid = 1'b1;
            step();
        end
        i_valid = 1'b0;
        drain_burst("after_reset", 16'h00A0);
        vec_cnt++;
        if (o_bvalid !== 1'b0 || o_fill !== 4'd0) begin
            err_cnt++;
            $display("FAIL after_reset_end: got bvalid=%b fill=%0d required 0 0", o_bvalid, o_fill);
        end
    endtask

    task automatic test_simul;
        o_bready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            i_data  = 16'h0051 + WIDTH'(i);
            i_valid = 1'b1;
            step();
        end
        i_valid  = 1'b0;
        o_bready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
        end
        vec_cnt++;
        if (o_fill !== 4'd4 || o_blast !== 1'b1 || o_bdata !== 16'h0054) begin
            err_cnt++;
            $display("FAIL simul_pre: got fill=%0d blast=%b bdata=%h required 4 1 0054",
                     o_fill, o_blast, o_bdata);
        end
        i_data  = 16'h0058;
        i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        vec_cnt++;
        if (o_fill !== 4'd4 || o_bvalid !== 1'b1) begin
            err_cnt++;
            $display("FAIL simul_post: got fill=%0d bvalid=%b required 4 1", o_fill, o_bvalid);
        end
        drain_burst("simul", 16'h0055);
        vec_cnt++;
        if (o_bvalid !== 1'b0 || o_fill !== 4'd0) begin
            err_cnt++;
            $display("FAIL simul_end: got bvalid=%b fill=%0d required 0 0", o_bvalid, o_fill);
        end
    endtask

    initial begin
        vec_cnt  = 0;
        err_cnt  = 0;
        rst      = 1'b1;
        i_data   = '0;
        i_valid  = 1'b0;
        o_bready = 1'b0;
        test_reset();
        test_basic();
        test_partial();
        test_full();
        test_stall();
        test_reset_mid();
        test_simul();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
